multicycle_alu: RTL and testbench

Parametrised, registered successor to the datapath ALU. It adds set-less-than, NOR, signed-overflow detection and an iterative unsigned multiply/divide unit behind a start/busy/done handshake. It sits in the execute stage of the multi-cycle datapath. The control FSM stalls on `busy` and captures `result`/`hi` when `done` pulses.

---
 rtl/multicycle_alu.sv | 229 ++++++++++++++++++++++
 tb/tb_multicycle_alu.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// multicycle_alu: registered ALU with add/sub/and/or/nor/slt and, when
// MULTICYCLE_ALU_MULDIV_EN is defined, an iterative unsigned multiply/divide
// unit (shift-add multiply, restoring divide, one bit per cycle).
//
// Handshake: a request is accepted on the rising edge where start is high and
// the FSM is not in RUN (i.e. IDLE or DONE). done is high for the cycle the FSM
// sits in DONE; result/hi/zero/ovf/divz are valid from then until the next
// accepted start. busy is high exactly while the FSM is in RUN; starts seen
// during RUN are dropped, not queued.
module multicycle_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       ALUctrl,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             ovf,
    output logic             divz,
    output logic             busy,
    output logic             done,
    output logic [1:0]       o_dbg_state,
    output logic [CNT_W-1:0] o_dbg_cnt
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_MULU = 3'b011;
    localparam logic [2:0] OP_DIVU = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_accept;
    logic             w_is_iter;
    logic             w_last;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_sc_result;
    logic [WIDTH-1:0] w_sc_hi;
    logic             w_sc_ovf;
    logic             w_sc_divz;

    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_hi;
    logic             r_zero;
    logic             r_ovf;
    logic             r_divz;

    assign w_sum  = in1 + in2;
    assign w_diff = in1 - in2;

    // Single-cycle results, computed straight from the request inputs.
    always_comb begin
        w_sc_result = '0;
        w_sc_hi     = '0;
        w_sc_ovf    = 1'b0;
        w_sc_divz   = 1'b0;
        case (ALUctrl)
            OP_ADD: begin
                w_sc_result = w_sum;
                w_sc_ovf    = (in1[WIDTH-1] == in2[WIDTH-1]) && (w_sum[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SUB: begin
                w_sc_result = w_diff;
                w_sc_ovf    = (in1[WIDTH-1] != in2[WIDTH-1]) && (w_diff[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_AND:  w_sc_result = in1 & in2;
            OP_OR:   w_sc_result = in1 | in2;
            OP_NOR:  w_sc_result = ~(in1 | in2);
            OP_SLT:  w_sc_result = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
`ifdef MULTICYCLE_ALU_MULDIV_EN
            // Divide by zero short-circuits the iterative unit.
            OP_DIVU: begin
                if (in2 == '0) begin
                    w_sc_result = '1;
                    w_sc_hi     = in1;
                    w_sc_divz   = 1'b1;
                end
            end
            OP_MULU: ;
`else
            // Without the iterative unit these complete immediately as zeros.
            OP_MULU, OP_DIVU: ;
`endif
            default: ;
        endcase
    end

`ifdef MULTICYCLE_ALU_MULDIV_EN
    logic [WIDTH-1:0] r_a;      // multiplicand / divisor
    logic [WIDTH-1:0] r_b;      // multiplier -> product low / dividend -> quotient
    logic [WIDTH-1:0] r_acc;    // product high / partial remainder
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH-1:0] w_div_sub;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_iter_acc;
    logic [WIDTH-1:0] w_iter_b;

    assign w_is_iter = (ALUctrl == OP_MULU) || ((ALUctrl == OP_DIVU) && (in2 != '0));
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

    // One iteration step: multiply adds then shifts {acc,b} right; divide
    // shifts {acc,b} left and restores unless the trial subtract fits.
    always_comb begin
        w_mul_sum   = {1'b0, r_acc} + (r_b[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
        w_div_shift = {r_acc, r_b[WIDTH-1]};
        w_div_ge    = (w_div_shift >= {1'b0, r_a});
        w_div_sub   = w_div_shift[WIDTH-1:0] - r_a;
        if (r_is_div) begin
            w_iter_acc = w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0];
            w_iter_b   = {r_b[WIDTH-2:0], w_div_ge};
        end else begin
            w_iter_acc = w_mul_sum[WIDTH:1];
            w_iter_b   = {w_mul_sum[0], r_b[WIDTH-1:1]};
        end
    end

    // Iterative datapath: load operands on acceptance, step once per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
        end else if (w_accept && w_is_iter) begin
            r_a      <= in2;
            r_b      <= in1;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_is_div <= (ALUctrl == OP_DIVU);
        end else if (r_state == S_RUN) begin
            r_acc    <= w_iter_acc;
            r_b      <= w_iter_b;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign o_dbg_cnt = r_cnt;
`else
    assign w_is_iter = 1'b0;
    assign w_last    = 1'b0;
    assign o_dbg_cnt = '0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // FSM next state; a start is taken in IDLE and DONE only.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = w_is_iter ? S_RUN : S_DONE;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_RUN:   if (w_last) w_next_state = S_DONE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output registers change only on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_hi     <= '0;
            r_zero   <= 1'b1;
            r_ovf    <= 1'b0;
            r_divz   <= 1'b0;
        end else if (w_accept && !w_is_iter) begin
            r_result <= w_sc_result;
            r_hi     <= w_sc_hi;
            r_zero   <= (w_sc_result == '0);
            r_ovf    <= w_sc_ovf;
            r_divz   <= w_sc_divz;
        end
`ifdef MULTICYCLE_ALU_MULDIV_EN
        else if ((r_state == S_RUN) && w_last) begin
            r_result <= w_iter_b;
            r_hi     <= w_iter_acc;
            r_zero   <= (w_iter_b == '0);
            r_ovf    <= 1'b0;
            r_divz   <= 1'b0;
        end
`endif
    end

    assign result      = r_result;
    assign hi          = r_hi;
    assign zero        = r_zero;
    assign ovf         = r_ovf;
    assign divz        = r_divz;
    assign done        = (r_state == S_DONE);
`ifdef MULTICYCLE_ALU_MULDIV_EN
    assign busy        = (r_state == S_RUN);
`else
    assign busy        = 1'b0;
`endif
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_multicycle_alu.sv
// Testbench for multicycle_alu (WIDTH=32). Table-driven vectors plus random
// ops checked by a scoreboard queue, and hand-written sequences for
// back-to-back starts, start during RUN, reset mid-RUN and reset vs start.
module tb_multicycle_alu;

    localparam int W = 32;
    localparam int CW = $clog2(W) + 1;
`ifdef MULTICYCLE_ALU_MULDIV_EN
    localparam int ITER_LAT = W + 1;
`else
    localparam int ITER_LAT = 1;
`endif

    // Packed expected record: {result, hi, zero, ovf, divz}
    localparam int EW = 2 * W + 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    ALUctrl;
    logic [W-1:0]  in1, in2;
    logic [W-1:0]  result, hi;
    logic          zero, ovf, divz, busy, done;
    logic [1:0]    dbg_state;
    logic [CW-1:0] dbg_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [EW-1:0] exp_q[$];

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         z;
        logic         ov;
        logic         dz;
        int           lat;
    } vec_t;

    vec_t vecs[17];

    multicycle_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .ALUctrl(ALUctrl),
        .in1(in1), .in2(in2), .result(result), .hi(hi), .zero(zero),
        .ovf(ovf), .divz(divz), .busy(busy), .done(done),
        .o_dbg_state(dbg_state), .o_dbg_cnt(dbg_cnt)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model, written independently with wide arithmetic.
    function automatic logic [EW-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r, h;
        logic ov, dz;
        longint s;
        logic [2*W-1:0] p;
        r = '0; h = '0; ov = 1'b0; dz = 1'b0; p = '0; s = 0;
        case (op)
            3'b010: begin
                r = a + b;
                s = longint'($signed(a)) + longint'($signed(b));
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'b110: begin
                r = a - b;
                s = longint'($signed(a)) - longint'($signed(b));
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b101: r = ~(a | b);
            3'b111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef MULTICYCLE_ALU_MULDIV_EN
            3'b011: begin
                p = {32'd0, a} * {32'd0, b};
                r = p[W-1:0];
                h = p[2*W-1:W];
            end
            3'b100: begin
                if (b == '0) begin r = '1; h = a; dz = 1'b1; end
                else begin r = a / b; h = a % b; end
            end
`endif
            default: ;
        endcase
        return {r, h, (r == '0), ov, dz};
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [W-1:0] b);
        if (op == 3'b011 || (op == 3'b100 && b != '0)) return ITER_LAT;
        return 1;
    endfunction

    // Scoreboard: every done cycle pops one expected record.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 128'(1), 128'(0));
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check("outputs{res,hi,z,ovf,divz}", 128'({result, hi, zero, ovf, divz}), 128'(e));
            end
        end
    end

    // Driver: issue one op, push its expectation, wait (bounded) for done.
    // With disturb set, inputs are scrambled and start pulsed mid-RUN.
    task automatic apply(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [EW-1:0] e, input int lat, input bit disturb, input string tag);
        int cyc, bcnt;
        @(negedge clk);
        start = 1'b1; ALUctrl = op; in1 = a; in2 = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_q.push_back(e);
        cyc = 0; bcnt = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (busy) bcnt++;
            if (disturb && cyc == 5) begin
                start = 1'b1; ALUctrl = 3'b010; in1 = $urandom; in2 = $urandom;
            end else if (disturb && cyc == 6) begin
                start = 1'b0; ALUctrl = 3'b100; in1 = $urandom; in2 = 32'd0;
            end
        end while (!done && cyc < 200);
        start = 1'b0;
        check({tag, "_latency"}, 128'(cyc), 128'(lat));
        check({tag, "_busy_cycles"}, 128'(bcnt), 128'(lat - 1));
    endtask

    initial begin
        // Vector table: op, a, b, result, hi, zero, ovf, divz, latency
        vecs[0]  = '{3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0, 1};
        vecs[1]  = '{3'b110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 1'b0, 1};
        vecs[2]  = '{3'b111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0, 1};
        vecs[3]  = '{3'b101, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1};
        vecs[4]  = '{3'b000, 32'h000000F0, 32'h0000000F, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1};
        vecs[5]  = '{3'b001, 32'h000000F0, 32'h0000000F, 32'h000000FF, 32'h0, 1'b0, 1'b0, 1'b0, 1};
        vecs[6]  = '{3'b010, 32'h00000005, 32'hFFFFFFFB, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1};
        vecs[7]  = '{3'b110, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1};
        vecs[8]  = '{3'b111, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1};
        vecs[9]  = '{3'b111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0, 1};
        vecs[10] = '{3'b110, 32'h00000000, 32'h80000000, 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0, 1};
        vecs[11] = '{3'b010, 32'h80000000, 32'h80000000, 32'h00000000, 32'h0, 1'b1, 1'b1, 1'b0, 1};
`ifdef MULTICYCLE_ALU_MULDIV_EN
        vecs[12] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 33};
        vecs[13] = '{3'b100, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 33};
        vecs[14] = '{3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b0, 1'b0, 1'b1, 1};
        vecs[15] = '{3'b011, 32'h00010000, 32'h00010000, 32'h00000000, 32'h1, 1'b1, 1'b0, 1'b0, 33};
        vecs[16] = '{3'b100, 32'd7, 32'd100, 32'd0, 32'd7, 1'b1, 1'b0, 1'b0, 33};
`else
        vecs[12] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1};
        vecs[13] = '{3'b100, 32'd100, 32'd7, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1};
        vecs[14] = '{3'b100, 32'd5, 32'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1};
        vecs[15] = '{3'b011, 32'h00010000, 32'h00010000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1};
        vecs[16] = '{3'b100, 32'd7, 32'd100, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1};
`endif

        // Reset block
        rst = 1'b1; start = 1'b0; ALUctrl = 3'b000; in1 = '0; in2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs{res,hi,z,ovf,divz,busy,done}",
              128'({result, hi, zero, ovf, divz, busy, done}),
              128'({32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
        check("reset_state", 128'(dbg_state), 128'(0));
        rst = 1'b0;

        // Table vectors
        for (int i = 0; i < 17; i++) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b,
                  {vecs[i].res, vecs[i].hi, vecs[i].z, vecs[i].ov, vecs[i].dz},
                  vecs[i].lat, (i == 12), $sformatf("vec%0d", i));
        end

        // Back-to-back single-cycle ops with start held high
        @(negedge clk);
        start = 1'b1; ALUctrl = 3'b010; in1 = 32'h7FFFFFFF; in2 = 32'h1;
        @(posedge clk); #1;
        exp_q.push_back({32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0});
        ALUctrl = 3'b110; in1 = 32'h80000000; in2 = 32'h1;
        @(negedge clk);
        check("b2b_done1", 128'(done), 128'(1));
        @(posedge clk); #1;
        exp_q.push_back({32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 1'b0});
        start = 1'b0;
        @(negedge clk);
        check("b2b_done2", 128'(done), 128'(1));
        @(negedge clk);
        check("b2b_done_drop", 128'(done), 128'(0));

        // Reset asserted mid-multiply: no done for the aborted op
        @(negedge clk);
        start = 1'b1; ALUctrl = 3'b011; in1 = 32'hFFFFFFFF; in2 = 32'hFFFFFFFF;
        @(posedge clk); #1;
        start = 1'b0;
`ifndef MULTICYCLE_ALU_MULDIV_EN
        exp_q.push_back({32'h0, 32'h0, 1'b1, 1'b0, 1'b0});
`endif
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrun_reset_outputs{res,hi,z,ovf,divz,busy,done}",
              128'({result, hi, zero, ovf, divz, busy, done}),
              128'({32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
        rst = 1'b0;
        begin
            int dcnt;
            dcnt = 0;
            repeat (40) begin
                @(negedge clk);
                if (done) dcnt++;
            end
            check("midrun_reset_no_done", 128'(dcnt), 128'(0));
        end
        apply(3'b010, 32'd2, 32'd3, {32'd5, 32'd0, 1'b0, 1'b0, 1'b0}, 1, 1'b0, "post_reset_add");

        // Reset and start on the same edge: reset wins
        @(negedge clk);
        rst = 1'b1; start = 1'b1; ALUctrl = 3'b010; in1 = 32'd1; in2 = 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("rst_vs_start{res,z,done}", 128'({result, zero, done}), 128'({32'h0, 1'b1, 1'b0}));
        rst = 1'b0;

        // Random ops against the model
        for (int i = 0; i < 24; i++) begin
            logic [2:0] op;
            logic [W-1:0] a, b;
            op = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            apply(op, a, b, model(op, a, b), model_lat(op, b), 1'b0, $sformatf("rand%0d", i));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
